// File: rtl/button_encoder_if.sv
// Button front-end bundle: raw button lines in, encoded colour / press pulse / status out.
interface button_encoder_if;
    logic [3:0] BTN;
    logic [1:0] IN;
    logic       IN_VALID;
    logic       BUSY;
    logic       STUCK;

    modport master (output BTN, input IN, IN_VALID, BUSY, STUCK);
    modport slave  (input BTN, output IN, IN_VALID, BUSY, STUCK);
endinterface

// File: rtl/button_encoder.sv
// Synchronise, debounce and encode four push buttons into one IN_VALID pulse per single press.
// Optional stuck-button detection is built when BUTTON_ENCODER_STUCK_DETECT_EN is defined.
module button_encoder #(
    parameter int DEBOUNCE_CYCLES = 20000,
    parameter int DB_W            = 15,
    parameter int STUCK_CYCLES    = 1000000,
    parameter int STK_W           = 20
) (
    input  logic             CLK,
    input  logic             RST_N,
    button_encoder_if.slave  bus
);

    localparam bit CFG_OK = (DEBOUNCE_CYCLES >= 2) &&
                            ((longint'(1) << DB_W) > longint'(DEBOUNCE_CYCLES)) &&
                            ((longint'(1) << STK_W) > longint'(STUCK_CYCLES));

    if (!CFG_OK) begin : g_bad_cfg
        $error("button_encoder: counter widths too small for the configured cycle counts");
    end

    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, HELD, REJECT} state_t;

    function automatic logic is_onehot(input logic [3:0] v);
        is_onehot = (v != 4'd0) && ((v & (v - 4'd1)) == 4'd0);
    endfunction

    function automatic logic [1:0] encode(input logic [3:0] v);
        encode = 2'd0;
        for (int k = 0; k < 4; k++)
            if (v[k]) encode = 2'(k);
    endfunction

    logic [3:0]      sync_p0;
    logic [3:0]      sync_p1;
    logic [3:0]      db_p2;
    logic [DB_W-1:0] cnt_p2 [4];
    state_t          state_p3, state_nx;
    logic [1:0]      in_p3, in_nx;
    logic            vld_p3, vld_nx;
    logic            busy_p3;

    // Stage p0/p1: two-flop synchroniser on the raw asynchronous lines
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            sync_p0 <= '0;
            sync_p1 <= '0;
        end else begin
            sync_p0 <= bus.BTN;
            sync_p1 <= sync_p0;
        end
    end

    // Stage p2: per-bit debounce; any return to the accepted level restarts the count
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            db_p2 <= '0;
            for (int k = 0; k < 4; k++) cnt_p2[k] <= '0;
        end else begin
            for (int k = 0; k < 4; k++) begin
                if (sync_p1[k] == db_p2[k]) begin
                    cnt_p2[k] <= '0;
                end else if (cnt_p2[k] == DB_LAST) begin
                    db_p2[k]  <= sync_p1[k];
                    cnt_p2[k] <= '0;
                end else begin
                    cnt_p2[k] <= cnt_p2[k] + DB_W'(1);
                end
            end
        end
    end

    always_comb begin
        state_nx = state_p3;
        in_nx    = in_p3;
        vld_nx   = 1'b0;
        case (state_p3)
            IDLE: begin
                if (db_p2 != 4'd0) begin
                    if (is_onehot(db_p2)) begin
                        in_nx    = encode(db_p2);
                        vld_nx   = 1'b1;
                        state_nx = HELD;
                    end else begin
                        state_nx = REJECT;
                    end
                end
            end
            HELD, REJECT: begin
                if (db_p2 == 4'd0) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // Stage p3: press FSM and registered outputs
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_p3 <= IDLE;
            in_p3    <= 2'd0;
            vld_p3   <= 1'b0;
            busy_p3  <= 1'b0;
        end else begin
            state_p3 <= state_nx;
            in_p3    <= in_nx;
            vld_p3   <= vld_nx;
            busy_p3  <= (db_p2 != 4'd0);
        end
    end

    assign bus.IN       = in_p3;
    assign bus.IN_VALID = vld_p3;
    assign bus.BUSY     = busy_p3;

`ifdef BUTTON_ENCODER_STUCK_DETECT_EN
    localparam logic [STK_W-1:0] STK_LAST = STK_W'(STUCK_CYCLES - 1);

    function automatic logic [STK_W-1:0] stk_sat_inc(input logic [STK_W-1:0] c);
        stk_sat_inc = (c == STK_LAST) ? c : c + STK_W'(1);
    endfunction

    logic [STK_W-1:0] stk_cnt_p3;
    logic             stuck_p3;

    // Cleared both while idle and on the edge that returns the FSM to idle
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            stk_cnt_p3 <= '0;
            stuck_p3   <= 1'b0;
        end else if (state_p3 == IDLE || state_nx == IDLE) begin
            stk_cnt_p3 <= '0;
            stuck_p3   <= 1'b0;
        end else begin
            stk_cnt_p3 <= stk_sat_inc(stk_cnt_p3);
            stuck_p3   <= stuck_p3 | (stk_cnt_p3 == STK_LAST);
        end
    end

    assign bus.STUCK = stuck_p3;
`else
    assign bus.STUCK = 1'b0;
`endif

endmodule

// File: tb/tb_button_encoder.sv
// Directed and randomized bench for button_encoder against a behavioural press model.
module tb_button_encoder;

    localparam int DC  = 4;
    localparam int DBW = 3;
    localparam int SC  = 32;
    localparam int SKW = 6;

    logic CLK   = 1'b0;
    logic RST_N = 1'b0;

    button_encoder_if bus ();

    button_encoder #(
        .DEBOUNCE_CYCLES(DC),
        .DB_W(DBW),
        .STUCK_CYCLES(SC),
        .STK_W(SKW)
    ) dut (
        .CLK(CLK),
        .RST_N(RST_N),
        .bus(bus)
    );

    always #5 CLK = ~CLK;

    // Reference model: a sampled level is accepted once DC consecutive samples disagree with it;
    // a press pulses when the accepted set goes from empty to exactly one button.
    logic [3:0] m_sync1, m_s, m_db, m_dbprev;
    logic [3:0] hist [DC];
    int         hist_n;
    logic [1:0] m_in;
    logic       m_vld, m_busy;
    int         run;

    int n_chk = 0, n_pass = 0, n_fail = 0;
    int cyc, pulses, pulse_cyc, stuck_rise, stuck_fall, busy_fall;
    logic [1:0] pulse_in;
    logic prev_stuck, prev_busy, stuck_seen;

    task automatic model_reset();
        m_sync1 = '0; m_s = '0; m_db = '0; m_dbprev = '0;
        for (int i = 0; i < DC; i++) hist[i] = '0;
        hist_n = 0; m_in = '0; m_vld = 1'b0; m_busy = 1'b0; run = 0;
    endtask

    task automatic model_edge(input logic [3:0] btn);
        logic [3:0] db_new;
        logic all_diff;
        for (int i = DC - 1; i > 0; i--) hist[i] = hist[i-1];
        hist[0] = m_s;
        if (hist_n < DC) hist_n++;
        db_new = m_db;
        for (int k = 0; k < 4; k++) begin
            if (hist_n >= DC) begin
                all_diff = 1'b1;
                for (int i = 0; i < DC; i++)
                    if (hist[i][k] == m_db[k]) all_diff = 1'b0;
                if (all_diff) db_new[k] = ~m_db[k];
            end
        end
        m_busy = (m_db != 4'd0);
        m_vld  = (m_dbprev == 4'd0) && ($countones(m_db) == 1);
        if (m_vld)
            for (int k = 0; k < 4; k++) if (m_db[k]) m_in = 2'(k);
        run = (m_dbprev != 4'd0 && m_db != 4'd0) ? run + 1 : 0;
        m_dbprev = m_db;
        m_db     = db_new;
        m_s      = m_sync1;
        m_sync1  = btn;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s cycle=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic check_outputs();
        logic exp_stuck;
`ifdef BUTTON_ENCODER_STUCK_DETECT_EN
        exp_stuck = (run >= SC);
`else
        exp_stuck = 1'b0;
`endif
        chk("IN", 32'(bus.IN), 32'(m_in));
        chk("IN_VALID", 32'(bus.IN_VALID), 32'(m_vld));
        chk("BUSY", 32'(bus.BUSY), 32'(m_busy));
        chk("STUCK", 32'(bus.STUCK), 32'(exp_stuck));
        if (bus.IN_VALID === 1'b1) begin
            pulses++; pulse_cyc = cyc; pulse_in = bus.IN;
        end
        if (bus.STUCK === 1'b1) stuck_seen = 1'b1;
        if (bus.STUCK === 1'b1 && !prev_stuck) stuck_rise = cyc;
        if (bus.STUCK === 1'b0 && prev_stuck) stuck_fall = cyc;
        if (bus.BUSY === 1'b0 && prev_busy) busy_fall = cyc;
        prev_stuck = (bus.STUCK === 1'b1);
        prev_busy  = (bus.BUSY === 1'b1);
    endtask

    task automatic tick();
        @(posedge CLK);
        if (RST_N) model_edge(bus.BTN);
        else       model_reset();
        #1;
        cyc++;
        check_outputs();
    endtask

    task automatic drive(input logic [3:0] btn, input int n);
        bus.BTN = btn;
        repeat (n) tick();
    endtask

    task automatic set_rst(input logic v);
        RST_N = v;
        if (!v) begin
            model_reset();
            #1;
            check_outputs();
        end
    endtask

    task automatic begin_scn();
        cyc = 0; pulses = 0; pulse_cyc = -1; pulse_in = 2'd0;
        stuck_rise = -1; stuck_fall = -1; busy_fall = -1; stuck_seen = 1'b0;
    endtask

    initial begin
        logic [3:0] rb;
        bus.BTN = 4'd0;
        prev_stuck = 1'b0; prev_busy = 1'b0;
        model_reset();
        begin_scn();
        repeat (3) tick();
        RST_N = 1'b1;
        drive(4'd0, 5);

        // Clean press
        begin_scn();
        drive(4'b0100, 20);
        drive(4'b0000, 20);
        chk("clean_pulses", 32'(pulses), 32'd1);
        chk("clean_cycle", 32'(pulse_cyc), 32'd7);
        chk("clean_in", 32'(pulse_in), 32'd2);

        // Bounce on button 0, settling at cycle 12
        begin_scn();
        for (int i = 0; i < 6; i++) drive((i % 2 == 0) ? 4'b0001 : 4'b0000, 2);
        drive(4'b0001, 18);
        drive(4'b0000, 15);
        chk("bounce_pulses", 32'(pulses), 32'd1);
        chk("bounce_cycle", 32'(pulse_cyc), 32'd19);
        chk("bounce_in", 32'(pulse_in), 32'd0);

        // Simultaneous press is rejected, a following single press is accepted
        begin_scn();
        drive(4'b0011, 10);
        drive(4'b0000, 17);
        chk("simul_pulses", 32'(pulses), 32'd0);
        drive(4'b1000, 10);
        drive(4'b0000, 15);
        chk("simul_next_pulses", 32'(pulses), 32'd1);
        chk("simul_next_in", 32'(pulse_in), 32'd3);

        // Overlapping second button does not re-report
        begin_scn();
        drive(4'b0001, 15);
        drive(4'b0011, 15);
        drive(4'b0000, 15);
        chk("overlap_pulses", 32'(pulses), 32'd1);
        chk("overlap_cycle", 32'(pulse_cyc), 32'd7);
        chk("overlap_in", 32'(pulse_in), 32'd0);
        begin_scn();
        drive(4'b0010, 10);
        drive(4'b0000, 15);
        chk("overlap_next_pulses", 32'(pulses), 32'd1);
        chk("overlap_next_in", 32'(pulse_in), 32'd1);

        // Reset mid-debounce with the button held throughout
        begin_scn();
        drive(4'b0010, 3);
        set_rst(1'b0);
        repeat (3) tick();
        RST_N = 1'b1;
        repeat (14) tick();
        drive(4'b0000, 15);
        chk("rst_pulses", 32'(pulses), 32'd1);
        chk("rst_cycle", 32'(pulse_cyc), 32'd13);
        chk("rst_in", 32'(pulse_in), 32'd1);

        // Long hold
        begin_scn();
        drive(4'b0001, 60);
        drive(4'b0000, 15);
        chk("hold_pulses", 32'(pulses), 32'd1);
`ifdef BUTTON_ENCODER_STUCK_DETECT_EN
        chk("stuck_rise", 32'(stuck_rise), 32'(pulse_cyc + SC));
        chk("stuck_fall", 32'(stuck_fall), 32'(busy_fall));
`else
        chk("stuck_never", 32'(stuck_seen), 32'd0);
`endif

        // Randomized presses, bounces, chords and resets
        begin_scn();
        for (int seg = 0; seg < 250; seg++) begin
            if ($urandom_range(0, 39) == 0) begin
                set_rst(1'b0);
                repeat ($urandom_range(1, 3)) tick();
                RST_N = 1'b1;
            end else begin
                case ($urandom_range(0, 4))
                    0, 1:    rb = 4'd0;
                    2, 3:    rb = 4'd1 << $urandom_range(0, 3);
                    default: rb = 4'($urandom_range(0, 15));
                endcase
                drive(rb, $urandom_range(1, 12));
            end
        end
        drive(4'd0, 15);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
